// File: rtl/trigger_capture_pkg.sv
// Shared types and elaboration helpers for the trigger capture buffer.
package trigger_capture_pkg;

    // Debug-visible FSM encoding; values are observed on the State port.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FILL    = 3'd1,
        ST_ARMED   = 3'd2,
        ST_POST    = 3'd3,
        ST_READOUT = 3'd4
    } captureState_t;

    localparam int STATE_W = 3;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    // Lane index width; a single lane still needs one bit of index.
    function automatic int laneIdxW(input int lanes);
        return (lanes > 1) ? clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/trigger_capture_buffer_ram.sv
// Simple dual-port capture memory: one write port, one registered read port.
module capture_ram
    import trigger_capture_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 10
)(
    input  logic              Clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write on demand, read every cycle; contents are never cleared.
    always_ff @(posedge Clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/trigger_capture_buffer.sv
// Circular ADC capture around a trigger edge, then lane-serial readout.
module trigger_capture_buffer
    import trigger_capture_pkg::*;
#(
    parameter int SAMPLE_W = 8,
    parameter int LANES    = 4,
    parameter int DEPTH    = 1024,
    parameter int PRETRIG  = 256
)(
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [LANES*SAMPLE_W-1:0] DataIn,
    input  logic                      DataInValid,
    input  logic                      FastTrigger,
    input  logic                      Arm,
    input  logic                      ReadStrobe,
    output logic [SAMPLE_W-1:0]       DataOut,
    output logic                      DataReady,
    output logic                      Armed,
    output logic                      Triggered,
    output logic                      Done,
    output logic [STATE_W-1:0]        State
);

    localparam int ADDR_W    = clog2(DEPTH);
    localparam int CNT_W     = ADDR_W + 1;
    localparam int LANE_W    = laneIdxW(LANES);
    localparam int POSTLEN   = DEPTH - PRETRIG;
    localparam int RD_STAGES = 1;

    captureState_t                      state;
    logic [ADDR_W-1:0]                  wptr;
    logic [ADDR_W-1:0]                  rptr;
    logic [ADDR_W-1:0]                  readStart;
    logic [CNT_W-1:0]                   cnt;
    logic [CNT_W-1:0]                   rdCnt;
    logic [LANE_W-1:0]                  laneIdx;
    logic                               trigQ;
    logic                               trigEdge;
    logic [RD_STAGES:0]                 vldPipe;
    logic                               ramWe;
    logic [LANES-1:0][SAMPLE_W-1:0]     ramRdata;
    logic [LANES-1:0][SAMPLE_W-1:0]     wordReg;

    assign trigEdge = FastTrigger & ~trigQ;
    assign ramWe    = DataInValid &&
                      ((state == ST_FILL) || (state == ST_ARMED) || (state == ST_POST));
    assign State    = state;

    capture_ram #(
        .DEPTH  (DEPTH),
        .WIDTH  (LANES*SAMPLE_W),
        .ADDR_W (ADDR_W)
    ) uRam (
        .Clock (Clock),
        .we    (ramWe),
        .waddr (wptr),
        .wdata (DataIn),
        .raddr (rptr),
        .rdata (ramRdata)
    );

    // Capture FSM, pointers, edge detector and lane serialiser.
    // vldPipe[0]: read address issued this cycle; vldPipe[1]: RAM word ready to load.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state     <= ST_IDLE;
            wptr      <= '0;
            rptr      <= '0;
            readStart <= '0;
            cnt       <= '0;
            rdCnt     <= '0;
            laneIdx   <= '0;
            trigQ     <= 1'b0;
            vldPipe   <= '0;
            wordReg   <= '0;
            DataOut   <= '0;
            DataReady <= 1'b0;
            Armed     <= 1'b0;
            Triggered <= 1'b0;
            Done      <= 1'b0;
        end else begin
            trigQ   <= FastTrigger;
            vldPipe <= {vldPipe[RD_STAGES-1:0], 1'b0};
            Done    <= 1'b0;
            if (ramWe) begin
                wptr <= wptr + 1'b1;
            end

            unique case (state)
                ST_IDLE: begin
                    // Arm is held off during the Done cycle itself.
                    if (Arm && !Done) begin
                        state <= ST_FILL;
                        wptr  <= '0;
                        cnt   <= '0;
                    end
                end

                ST_FILL: begin
                    if (DataInValid) begin
                        if (cnt == CNT_W'(PRETRIG - 1)) begin
                            state <= ST_ARMED;
                            Armed <= 1'b1;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                ST_ARMED: begin
                    if (trigEdge) begin
                        Armed     <= 1'b0;
                        Triggered <= 1'b1;
                        readStart <= wptr - ADDR_W'(PRETRIG);
                        // With a one-word post window the trigger word completes it.
                        if (DataInValid && (POSTLEN == 1)) begin
                            state      <= ST_READOUT;
                            rptr       <= wptr - ADDR_W'(PRETRIG);
                            rdCnt      <= '0;
                            vldPipe[0] <= 1'b1;
                        end else begin
                            state <= ST_POST;
                            cnt   <= DataInValid ? CNT_W'(1) : '0;
                        end
                    end
                end

                ST_POST: begin
                    if (DataInValid) begin
                        if (cnt == CNT_W'(POSTLEN - 1)) begin
                            state      <= ST_READOUT;
                            rptr       <= readStart;
                            rdCnt      <= '0;
                            vldPipe[0] <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                ST_READOUT: begin
                    if (vldPipe[RD_STAGES]) begin
                        // Latch the fetched word and present lane 0; rptr moves on
                        // so the RAM output already holds the next word.
                        wordReg   <= ramRdata;
                        DataOut   <= ramRdata[0];
                        laneIdx   <= '0;
                        DataReady <= 1'b1;
                        rptr      <= rptr + 1'b1;
                        rdCnt     <= rdCnt + 1'b1;
                    end else if (DataReady && ReadStrobe) begin
                        if (laneIdx == LANE_W'(LANES - 1)) begin
                            DataReady <= 1'b0;
                            if (rdCnt == CNT_W'(DEPTH)) begin
                                state     <= ST_IDLE;
                                Triggered <= 1'b0;
                                Done      <= 1'b1;
                            end else begin
                                // One-cycle fetch bubble before the next word.
                                vldPipe[RD_STAGES] <= 1'b1;
                            end
                        end else begin
                            laneIdx <= laneIdx + 1'b1;
                            DataOut <= wordReg[laneIdx + 1'b1];
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trigger_capture_buffer.sv
// Directed + randomized bench for trigger_capture_buffer with a window-level model.
module tb_trigger_capture_buffer;

    localparam int SAMPLE_W = 8;
    localparam int LANES    = 4;
    localparam int DEPTH    = 16;
    localparam int PRETRIG  = 4;
    localparam int POSTLEN  = DEPTH - PRETRIG;

    logic                      Clock;
    logic                      Reset;
    logic [LANES*SAMPLE_W-1:0] DataIn;
    logic                      DataInValid;
    logic                      FastTrigger;
    logic                      Arm;
    logic                      ReadStrobe;
    logic [SAMPLE_W-1:0]       DataOut;
    logic                      DataReady;
    logic                      Armed;
    logic                      Triggered;
    logic                      Done;
    logic [2:0]                State;

    int total = 0;
    int bad   = 0;
    int n     = 0;
    logic [7:0] expQ [$];

    trigger_capture_buffer #(
        .SAMPLE_W (SAMPLE_W),
        .LANES    (LANES),
        .DEPTH    (DEPTH),
        .PRETRIG  (PRETRIG)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .DataIn      (DataIn),
        .DataInValid (DataInValid),
        .FastTrigger (FastTrigger),
        .Arm         (Arm),
        .ReadStrobe  (ReadStrobe),
        .DataOut     (DataOut),
        .DataReady   (DataReady),
        .Armed       (Armed),
        .Triggered   (Triggered),
        .Done        (Done),
        .State       (State)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [31:0] mkWord(input int w);
        logic [31:0] r;
        for (int l = 0; l < LANES; l++) r[l*8 +: 8] = 8'(w + l);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge Clock);
        #1;
        n++;
        DataIn = mkWord(n);
    endtask

    // One full capture. Offset k counts cycles from the Arm cycle (k=0); the word
    // presented at offset k is armN+k. FastTrigger is high on [e1,e1+h1) and [e2,e2+2).
    // mode 0: ReadStrobe held high; mode 1: random ReadStrobe/Arm/FastTrigger.
    // abortAt >= 0: reset once that many samples have been consumed.
    task automatic capture(input int armN, input int e1, input int h1, input int e2,
                           input int mode, input int abortAt);
        bit ft [64];
        int kt, k, c, got, firstRdy;
        bit fin, aborted;
        kt = -1;
        for (int i = 0; i < 64; i++)
            ft[i] = ((i >= e1) && (i < e1 + h1)) || ((i >= e2) && (i < e2 + 2));
        // First rising edge once PRETRIG words are stored is the trigger word.
        for (int i = PRETRIG + 1; i < 64; i++)
            if (kt < 0 && ft[i] && !ft[i-1]) kt = i;
        expQ.delete();
        for (int w = 0; w < DEPTH; w++)
            for (int l = 0; l < LANES; l++)
                expQ.push_back(8'(armN + kt - PRETRIG + w + l));

        n = armN;
        DataIn = mkWord(n);
        ReadStrobe = 1'b0;
        for (k = 0; k <= kt; k++) begin
            Arm = (k == 0);
            FastTrigger = ft[k];
            check("state_pre", State, (k == 0) ? 0 : (k <= PRETRIG) ? 1 : 2);
            if (k == PRETRIG + 1) check("armed", Armed, 1);
            if (k == kt) check("trig_before_edge", Triggered, 0);
            cyc();
        end
        k = kt + 1;
        Arm = 1'($urandom_range(0, 1));
        FastTrigger = (k < 64) ? ft[k] : 1'b0;
        check("state_post", State, 3);
        check("triggered", Triggered, 1);
        check("armed_post", Armed, 0);
        while (State !== 3'd4 && k < kt + 40) begin
            cyc();
            k++;
            Arm = 1'($urandom_range(0, 1));
            FastTrigger = (k < 64) ? ft[k] : 1'b0;
        end
        check("post_len", k - kt, POSTLEN);

        c = 0; got = 0; firstRdy = -1; fin = 0; aborted = 0;
        while (!fin && !aborted && c < 3000) begin
            if (DataReady === 1'b1 && firstRdy < 0) begin
                firstRdy = c;
                check("first_rdy_lat", c, 2);
            end
            if (mode == 0 && firstRdy >= 0)
                check("rdy_pattern", DataReady, ((c - firstRdy) % (LANES + 1)) != LANES);
            if (Done === 1'b1) begin
                check("done_count", got, DEPTH * LANES);
                check("done_state", State, 0);
                check("done_rdy", DataReady, 0);
                check("done_trig", Triggered, 0);
                if (mode == 0) check("done_time", c - firstRdy, DEPTH * (LANES + 1) - 1);
                fin = 1;
            end else begin
                if (DataReady === 1'b1) begin
                    if (expQ.size() == 0) check("extra_sample", 1, 0);
                    else check("sample", DataOut, expQ[0]);
                end
                ReadStrobe  = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                Arm         = (mode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
                FastTrigger = (mode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
                if (ReadStrobe && DataReady === 1'b1) begin
                    if (expQ.size() > 0) void'(expQ.pop_front());
                    got++;
                end
                cyc();
                c++;
                if (abortAt >= 0 && got == abortAt) begin
                    Reset = 1'b0; Arm = 1'b0; ReadStrobe = 1'b0; FastTrigger = 1'b0;
                    cyc();
                    check("abort_rdy", DataReady, 0);
                    check("abort_state", State, 0);
                    check("abort_done", Done, 0);
                    Reset = 1'b1;
                    cyc();
                    check("abort_done2", Done, 0);
                    aborted = 1;
                end
            end
        end
        Arm = 1'b0; ReadStrobe = 1'b0; FastTrigger = 1'b0;
        if (!fin && !aborted) begin
            check("readout_timeout", 1, 0);
        end else if (fin) begin
            cyc();
            check("done_pulse", Done, 0);
            check("idle_after", State, 0);
        end
    endtask

    initial begin
        int armN, e1, h1, e2;
        Reset = 1'b0;
        Arm = 1'($urandom_range(0, 1));
        FastTrigger = 1'($urandom_range(0, 1));
        ReadStrobe = 1'($urandom_range(0, 1));
        DataInValid = 1'b1;
        DataIn = $urandom;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clock);
            #1;
            check("rst_state", State, 0);
            check("rst_out", {DataOut, DataReady, Armed, Triggered, Done}, 0);
            Arm = 1'($urandom_range(0, 1));
            FastTrigger = 1'($urandom_range(0, 1));
            ReadStrobe = 1'($urandom_range(0, 1));
            DataInValid = 1'($urandom_range(0, 1));
            DataIn = $urandom;
        end
        Reset = 1'b1; Arm = 1'b0; FastTrigger = 1'b0; ReadStrobe = 1'b0; DataInValid = 1'b1;
        cyc();

        capture(15, 5, 2, 20, 0, -1);   // basic: trigger word 20, window 16..31
        capture(-1, 3, 2, 7, 1, -1);    // edge in FILL ignored; trigger word 6
        capture(30, 7, 3, 12, 0, -1);   // trigger word 37, window 33..48 wraps RAM
        capture(100, 3, 6, 10, 1, -1);  // level held through ARMED does not retrigger
        capture(50, 6, 1, 9, 0, 10);    // reset after 10 samples consumed
        capture(70, 5, 2, 8, 1, -1);    // clean capture after the abort
        for (int r = 0; r < 5; r++) begin
            armN = $urandom_range(0, 255);
            e1 = $urandom_range(1, 8);
            h1 = $urandom_range(1, 6);
            e2 = e1 + h1 + $urandom_range(1, 4);
            if (e2 < PRETRIG + 1) e2 = PRETRIG + 1;
            capture(armN, e1, h1, e2, $urandom_range(0, 1), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trigger_capture_buffer.md
Name: trigger_capture_buffer

Overview:
Single-clock, parametrised successor to the fast-trigger data storage block. It continuously records multi-lane ADC words into a circular buffer and freezes a window around a trigger edge, keeping a programmable pre-trigger depth. It then serialises the stored window one lane sample at a time to the UART transmit wrapper using a DataReady/ReadStrobe handshake. It sits between the ADC deserialiser and the TX path, with both in the Clock domain.

Parameters:
SAMPLE_W, 8, bits per lane sample (= DataOut width)
LANES, 4, samples per input word
DEPTH, 1024, buffer depth in words; power of 2, >= 4
PRETRIG, 256, words kept before the trigger word; 1 <= PRETRIG < DEPTH
ADDR_W, clog2(DEPTH), derived; not overridden

Ports:
Clock  in  1  system clock; all logic on rising edge
Reset  in  1  synchronous, active-low reset
DataIn  in  LANES*SAMPLE_W  lane k = DataIn[k*SAMPLE_W +: SAMPLE_W]
DataInValid  in  1  DataIn word is valid this cycle
FastTrigger  in  1  trigger level; acted on at its rising edge only
Arm  in  1  one-cycle start request; honoured in IDLE only
ReadStrobe  in  1  consumer takes DataOut this cycle
DataOut  out  SAMPLE_W  current readout sample, registered
DataReady  out  1  DataOut is valid
Armed  out  1  high in ARMED
Triggered  out  1  high in POST and READOUT
Done  out  1  one-cycle pulse after the last sample is consumed
State  out  3  encoded FSM state, for debug

Behaviour:
- Reset (Reset==0 at a clock edge):
  - State=IDLE; DataOut, DataReady, Armed, Triggered and Done all 0.
  - Write pointer, counters and the trigger-edge register cleared.
  - RAM contents are not cleared.
  - Reset dominates every other input; it is legal in any state, including mid-READOUT.
- Trigger edge: trig_q registers FastTrigger every cycle. edge = FastTrigger & ~trig_q. A level held high does not retrigger.
- IDLE:
  - Arm=1 -> FILL; wptr=0, fill count=0.
  - Arm during FILL, ARMED, POST or READOUT is ignored.
- FILL:
  - Each DataInValid writes DataIn at wptr, then wptr=(wptr+1) mod DEPTH.
  - After PRETRIG words have been written -> ARMED.
  - Edges in FILL are ignored.
- ARMED:
  - Writing continues and wraps freely.
  - On edge -> POST; trigger address T = wptr at that cycle.
  - The trigger word is the word written at T: this cycle's word if DataInValid=1, otherwise the next valid word.
  - Read start S = (T - PRETRIG) mod DEPTH.
- POST:
  - Writes continue; the post counter counts written words including the trigger word.
  - When DEPTH-PRETRIG words have been written -> READOUT.
  - Further edges are ignored.
- READOUT:
  - Input writes are suppressed; DataInValid is ignored.
  - Reads DEPTH words starting at S, wrapping mod DEPTH, each serialised lane 0 first up to lane LANES-1.
  - Total output is DEPTH*LANES samples.
  - RAM read latency is 1 cycle. The first DataReady rises 2 cycles after READOUT entry.
- Handshake:
  - ReadStrobe & DataReady consumes the sample. The next lane appears the following cycle with DataReady held high.
  - After consuming lane LANES-1, DataReady drops for exactly 1 cycle (fetch bubble), then the next word's lane 0 is presented.
  - ReadStrobe while DataReady=0 is ignored.
  - DataOut holds its value until consumed.
- End of readout:
  - Consuming the last sample -> DataReady=0, Done=1 for one cycle, State=IDLE.
  - The next Arm is accepted from the cycle after Done.
- Pointer and counter arithmetic is ADDR_W-bit modular; the counters are ADDR_W+1 bits.
- State encoding: IDLE=0, FILL=1, ARMED=2, POST=3, READOUT=4.

Decomposition:
- Package trigger_capture_pkg: state encoding constants, clog2 function, lane-index width helper.
- Sub-module capture_ram:
  - Single-clock simple dual-port RAM, DEPTH x LANES*SAMPLE_W, registered read, no reset.
  - Write port: we/waddr/wdata. Read port: raddr/rdata.
- FSM, pointers, edge detector and lane serialiser live in trigger_capture_buffer.

Test Plan:
All scenarios use DEPTH=16, PRETRIG=4, LANES=4, SAMPLE_W=8, DataInValid=1 each cycle, and DataIn = {n+3,n+2,n+1,n} (8-bit wrap) for word n.
- Reset check: hold Reset=0 for 3 cycles with random inputs -> all outputs 0, State=0. Release, then Arm -> State=1 next cycle, State=2 after 4 words.
- Basic capture: Arm; trigger edge aligned with word 20 -> Triggered=1. Readout has 64 samples, starting with word 16 (bytes 16,17,18,19) and ending with word 31 (31,32,33,34). Done pulses once.
- FILL ignore: edge at word 2 is ignored (State stays FILL); edge at word 6 -> S corresponds to word 2, and the first samples are 2,3,4,5.
- Wrap-around: edge at word 37 -> readout is words 33..48 in order across the RAM wrap; no sample is missing or duplicated.
- Handshake: ReadStrobe held at 1 -> DataReady pattern is 1,1,1,1,0 repeating, with 64 consumes over 80 cycles. ReadStrobe pulses while DataReady=0 do not advance the stream.
- Reset mid-readout: Reset=0 after 10 samples consumed -> DataReady=0 and State=IDLE next edge, no Done. Re-Arm and trigger -> a correct 64-sample capture.
